// File: rtl/wm_pkg.sv
// wm_pkg: state codes shared by the cycle controller and the timer block, plus the watchdog default limit.
package wm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOCK  = 3'd1,
        FILL  = 3'd2,
        HEAT  = 3'd3,
        WASH  = 3'd4,
        RINSE = 3'd5,
        SPIN  = 3'd6,
        DONE  = 3'd7
    } wm_state_t;

    localparam int WDOG_LIMIT_DEFAULT = 16;

    // States that wait on a timer flag and are therefore watched for stalls.
    function automatic logic is_timed(wm_state_t s);
        return s inside {FILL, HEAT, WASH, RINSE, SPIN};
    endfunction

endpackage

// File: rtl/wm_watchdog.sv
// wm_watchdog: counts cycles spent in one timed state and flags expiry on the last allowed cycle.
module wm_watchdog
    import wm_pkg::*;
#(
    parameter int LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    assign expired = enable && cnt_q == LAST;

    // Restart on every state change, otherwise count up and hold at the last value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else if (enable && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/wm_cycle_controller.sv
// wm_cycle_controller: washing-machine cycle FSM with registered Moore actuator outputs.
// Define WM_WATCHDOG_EN to build the stall watchdog and the sticky err flag.
module wm_cycle_controller
    import wm_pkg::*;
#(
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       door_closed,
    input  logic       cancel,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    output logic [2:0] state,
    output logic       water_valve,
    output logic       heater,
    output logic       motor_wash,
    output logic       drain_pump,
    output logic       motor_spin,
    output logic       door_lock,
    output logic       done,
    output logic       err
);

    if (WDOG_LIMIT < 2) begin : g_bad_limit
        $error("WDOG_LIMIT must be at least 2");
    end

    wm_state_t state_q, state_d;
    logic      wdog_trip;

    assign state = state_q;

`ifdef WM_WATCHDOG_EN
    logic err_q;

    wm_watchdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_d != state_q),
        .enable  (is_timed(state_q)),
        .expired (wdog_trip)
    );

    // Sticky fault: set on a watchdog trip, cleared when the next cycle is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else if (wdog_trip) err_q <= 1'b1;
        else if (state_q == IDLE && state_d == LOCK) err_q <= 1'b0;
    end

    assign err = err_q;
`else
    assign wdog_trip = 1'b0;
    assign err       = 1'b0;
`endif

    // Next state: cancel beats the done flags, the watchdog beats everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = (start && door_closed) ? LOCK : IDLE;
            LOCK:  state_d = FILL;
            FILL:  state_d = cancel ? SPIN : sig_Full ? HEAT : FILL;
            HEAT:  state_d = cancel ? SPIN : sig_Temperature ? WASH : HEAT;
            WASH:  state_d = cancel ? SPIN : sig_Completed ? RINSE : WASH;
            RINSE: state_d = (cancel || sig_Completed) ? SPIN : RINSE;
            SPIN:  state_d = sig_Completed ? DONE : SPIN;
            DONE:  state_d = door_closed ? DONE : IDLE;
        endcase
        if (wdog_trip) state_d = IDLE;
    end

    // State register with actuators decoded from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            water_valve <= 1'b0;
            heater      <= 1'b0;
            motor_wash  <= 1'b0;
            drain_pump  <= 1'b0;
            motor_spin  <= 1'b0;
            door_lock   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            water_valve <= state_d inside {FILL, RINSE};
            heater      <= state_d == HEAT;
            motor_wash  <= state_d inside {WASH, RINSE};
            drain_pump  <= state_d inside {RINSE, SPIN};
            motor_spin  <= state_d == SPIN;
            door_lock   <= state_d == LOCK || is_timed(state_d);
            done        <= state_d == DONE;
        end
    end

endmodule

// File: doc/wm_cycle_controller.md
WM_CYCLE_CONTROLLER -- requirements
Module: wm_cycle_controller

Interface
REQ-001 Parameter WDOG_LIMIT, default 16, is the maximum cycles allowed in any timed state before a watchdog fault.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a wash cycle; level-sampled.
REQ-005 door_closed  input  1  door sensor; 1 = closed.
REQ-006 cancel  input  1  abort the running cycle via drain/spin.
REQ-007 sig_Full, sig_Temperature, sig_Completed  input  1 each  timer done flags for fill, heat and wash/rinse/spin.
REQ-008 state  output  3  current state code; drives the timer block.
REQ-009 water_valve, heater, motor_wash, drain_pump, motor_spin  output  1 each  actuator enables.
REQ-010 door_lock  output  1  door locked.
REQ-011 done  output  1  cycle finished.
REQ-012 err  output  1  sticky watchdog fault flag.

Function
REQ-013 The FSM SHALL use codes IDLE=0, LOCK=1, FILL=2, HEAT=3, WASH=4, RINSE=5, SPIN=6, DONE=7, driven directly on state.
REQ-014 IDLE->LOCK when start=1 and door_closed=1; otherwise stay in IDLE.
REQ-015 LOCK->FILL after exactly one cycle.
REQ-016 FILL->HEAT on sig_Full; HEAT->WASH on sig_Temperature; WASH->RINSE, RINSE->SPIN and SPIN->DONE each on sig_Completed.
REQ-017 DONE->IDLE when door_closed=0; otherwise stay in DONE.
REQ-018 cancel=1 in FILL, HEAT, WASH or RINSE SHALL force the next state to SPIN, overriding any done flag that cycle.
REQ-019 cancel SHALL be ignored in IDLE, LOCK, SPIN and DONE.
REQ-020 The done flags SHALL be ignored outside their own states.
REQ-021 door_closed SHALL be ignored from LOCK through SPIN.
REQ-022 All outputs SHALL be registered Moore decodes of the state register, with no combinational input-to-output path.
REQ-023 Actuator decode:
  - water_valve = FILL or RINSE
  - heater = HEAT
  - motor_wash = WASH or RINSE
  - drain_pump = RINSE or SPIN
  - motor_spin = SPIN
  - door_lock = LOCK through SPIN
  - done = DONE
REQ-024 heater and water_valve SHALL never be 1 in the same cycle.
REQ-025 A new start SHALL be accepted only in IDLE.
REQ-026 start held high in DONE SHALL NOT restart the cycle until IDLE is reached.

Reset
REQ-027 While reset_n=0: state=IDLE, all actuators, door_lock, done and err = 0, and the watchdog counter = 0, all asynchronously.
REQ-028 Reset asserted mid-cycle SHALL abort immediately with no drain sequence.
REQ-029 Operation SHALL resume from IDLE on the first clock edge after reset_n rises.

Configuration
REQ-030 With WM_WATCHDOG_EN defined:
  - a counter clears on every state change and increments each cycle in FILL, HEAT, WASH, RINSE and SPIN, saturating;
  - reaching WDOG_LIMIT-1 without the expected flag SHALL force IDLE next cycle and set err=1;
  - err SHALL clear on the next IDLE->LOCK transition;
  - watchdog has priority over cancel and over the done flags.
REQ-031 Without WM_WATCHDOG_EN, no counter logic is built, err is tied to 0, and timed states wait indefinitely.

Structure
REQ-032 A shared package wm_pkg SHALL hold:
  - the 3-bit state encodings, used by both this block and the timer;
  - the WDOG_LIMIT default.
REQ-033 The watchdog SHALL be one sub-module, wm_watchdog (inputs: clear, enable; output: expired), instantiated only under WM_WATCHDOG_EN.

Verification
REQ-034 Nominal cycle: start=1 with door closed; flags pulsed 3 cycles after entering each state -> state sequence 0,1,2,3,4,5,6,7; door_lock=1 throughout 1..6; done=1 in 7; door opened -> state 0.
REQ-035 Cancel in WASH: cancel=1 with sig_Completed=1 in the same cycle -> next state=6 (not 5); drain_pump=motor_spin=1; sig_Completed -> 7.
REQ-036 Door open at start: start=1, door_closed=0 for 10 cycles -> state stays 0 and all outputs stay 0.
REQ-037 Watchdog (macro on, WDOG_LIMIT=16): sig_Temperature never asserted in HEAT -> state returns to 0 after exactly 16 cycles in HEAT with err=1; next start -> err=0 on entering LOCK.
REQ-038 Reset mid-RINSE: reset_n=0 asynchronously -> state=0 and all outputs 0 before the next clock edge.
REQ-039 Stray flags: sig_Full pulsed in IDLE, then sig_Completed pulsed in HEAT -> no state change.
